// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified RAM between the IF and
// MEM pipeline stages with a registered request/acknowledge transaction,
// per-requester stall levels and a ram_ack timeout that sets a sticky bus_err.
// Optional feature: define ARB_RR_EN for round-robin tie-breaking
// (otherwise MEM has fixed priority over IF).
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_data,
    output logic                  if_ack,
    input  logic                  mem_req,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_din,
    output logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  mem_ack,
    output logic                  if_stall,
    output logic                  mem_stall,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_ack,
    output logic                  bus_err
);

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM, RESP} state_t;

    localparam logic [7:0] TO_VAL = 8'(TIMEOUT);
    localparam logic       TO_EN  = (TIMEOUT != 0);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  if_ack_q, if_ack_d;
    logic                  mem_ack_q, mem_ack_d;
    logic [DATA_WIDTH-1:0] if_data_q, if_data_d;
    logic [DATA_WIDTH-1:0] mem_dout_q, mem_dout_d;
    logic                  bus_err_q, bus_err_d;
    logic                  pick_mem;
    logic                  is_mem;
    logic                  timed_out;
`ifdef ARB_RR_EN
    logic                  last_mem_q, last_mem_d;  // 1: MEM was granted last
`endif

    // Arbitration choice made in IDLE
`ifdef ARB_RR_EN
    always_comb pick_mem = mem_req & (~if_req | ~last_mem_q);
`else
    always_comb pick_mem = mem_req;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cs_d       = cs_q;
        we_d       = we_q;
        addr_d     = addr_q;
        din_d      = din_q;
        if_ack_d   = 1'b0;
        mem_ack_d  = 1'b0;
        if_data_d  = if_data_q;
        mem_dout_d = mem_dout_q;
        bus_err_d  = bus_err_q;
`ifdef ARB_RR_EN
        last_mem_d = last_mem_q;
`endif
        is_mem     = (state_q == GNT_MEM);
        timed_out  = TO_EN && (cnt_q == TO_VAL);

        case (state_q)
            IDLE: begin
                if (pick_mem) begin
                    state_d = GNT_MEM;
                    cs_d    = 1'b1;
                    we_d    = mem_wen;
                    addr_d  = mem_addr;
                    din_d   = mem_din;
                    cnt_d   = '0;
`ifdef ARB_RR_EN
                    last_mem_d = 1'b1;
`endif
                end else if (if_req) begin
                    state_d = GNT_IF;
                    cs_d    = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    cnt_d   = '0;
`ifdef ARB_RR_EN
                    last_mem_d = 1'b0;
`endif
                end
            end
            GNT_IF, GNT_MEM: begin
                if (ram_ack || timed_out) begin
                    state_d   = RESP;
                    cs_d      = 1'b0;
                    we_d      = 1'b0;
                    if_ack_d  = ~is_mem;
                    mem_ack_d = is_mem;
                    // A timed-out read returns zero instead of bus garbage
                    if (!is_mem) begin
                        if_data_d = ram_ack ? ram_dout : '0;
                    end else if (!we_q) begin
                        mem_dout_d = ram_ack ? ram_dout : '0;
                    end
                    if (!ram_ack) begin
                        bus_err_d = 1'b1;
                    end
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            if_ack_q   <= 1'b0;
            mem_ack_q  <= 1'b0;
            if_data_q  <= '0;
            mem_dout_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            if_ack_q   <= if_ack_d;
            mem_ack_q  <= mem_ack_d;
            if_data_q  <= if_data_d;
            mem_dout_q <= mem_dout_d;
            bus_err_q  <= bus_err_d;
        end
    end

`ifdef ARB_RR_EN
    // Round-robin history, reset to IF so MEM wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_mem_q <= 1'b0;
        else     last_mem_q <= last_mem_d;
    end
`endif

    assign ram_cs    = cs_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_din   = din_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign if_data   = if_data_q;
    assign mem_dout  = mem_dout_q;
    assign bus_err   = bus_err_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign mem_stall = mem_req & ~mem_ack_q;

endmodule
